// File: rtl/hour_chime_ctrl_if.sv
// Clock-time inputs and chime outputs shared between the chime sequencer and its user.
// The master drives time/config and the slave (the sequencer) returns tone/busy/done.
interface hour_chime_ctrl_if #(
   parameter int TONE_W = 20
);
   logic              en;
   logic [5:0]        hour;
   logic [5:0]        min;
   logic [5:0]        sec;
   logic [4:0]        quiet_start;
   logic [4:0]        quiet_end;
   logic [TONE_W-1:0] tone;
   logic              busy;
   logic              done;

   modport master (
      output en, hour, min, sec, quiet_start, quiet_end,
      input  tone, busy, done
   );

   modport slave (
      input  en, hour, min, sec, quiet_start, quiet_end,
      output tone, busy, done
   );
endinterface

// File: rtl/hour_chime_ctrl.sv
// Hourly/half-hourly strike sequencer: tone is registered and follows a trigger tick by one clock.
// There is no backpressure; a trigger while a sequence is running is dropped, and en low aborts at once.
module hour_chime_ctrl #(
   parameter int TONE_W       = 20,
   parameter int TONE_HOUR    = 20000,
   parameter int TONE_HALF    = 30000,
   parameter int STRIKE_ON_S  = 1,
   parameter int STRIKE_GAP_S = 1,
   parameter int MODE24       = 0,
   parameter int HALF_EN      = 1
) (
   input logic               clk,
   input logic               rst,
   hour_chime_ctrl_if.slave  bus_if
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [3:0]        ON_T      = 4'(STRIKE_ON_S);
   localparam logic [3:0]        GAP_T     = 4'(STRIKE_GAP_S);
   localparam logic [TONE_W-1:0] TONE_HR_V = TONE_W'(TONE_HOUR);
   localparam logic [TONE_W-1:0] TONE_HF_V = TONE_W'(TONE_HALF);

   logic [1:0]        state_q, state_d;
   logic [4:0]        rem_q, rem_d;
   logic [3:0]        t_q, t_d;
   logic [5:0]        sec_q;
   logic [TONE_W-1:0] tone_q, tone_d;
   logic [TONE_W-1:0] val_q, val_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic       tick;
   logic       quiet;
   logic       hour_trig;
   logic       half_trig;
   logic [4:0] n_hour;
   logic [5:0] qs, qe;

   assign tick      = (bus_if.sec != sec_q);
   assign qs        = {1'b0, bus_if.quiet_start};
   assign qe        = {1'b0, bus_if.quiet_end};
   assign hour_trig = (bus_if.min == 6'd0) && (bus_if.sec == 6'd0);
   assign half_trig = (HALF_EN != 0) && (bus_if.min == 6'd30) && (bus_if.sec == 6'd0);

   // Equal bounds mean no quiet window; start > end wraps through midnight.
   always_comb begin
      quiet = 1'b0;
      if (qs < qe) begin
         quiet = (bus_if.hour >= qs) && (bus_if.hour < qe);
      end else if (qs > qe) begin
         quiet = (bus_if.hour >= qs) || (bus_if.hour < qe);
      end
   end

   always_comb begin
      n_hour = bus_if.hour[4:0];
      if (MODE24 != 0) begin
         if (bus_if.hour == 6'd0) n_hour = 5'd24;
      end else begin
         if (bus_if.hour >= 6'd12) n_hour = bus_if.hour[4:0] - 5'd12;
         if (n_hour == 5'd0) n_hour = 5'd12;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      t_d     = t_q;
      tone_d  = tone_q;
      val_d   = val_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (!bus_if.en) begin
         state_d = S_IDLE;
         t_d     = 4'd0;
         rem_d   = 5'd0;
         tone_d  = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tick && !quiet && (hour_trig || half_trig)) begin
                  state_d = S_ON;
                  t_d     = 4'd0;
                  busy_d  = 1'b1;
                  rem_d   = hour_trig ? n_hour : 5'd1;
                  val_d   = hour_trig ? TONE_HR_V : TONE_HF_V;
                  tone_d  = hour_trig ? TONE_HR_V : TONE_HF_V;
               end
            end
            S_ON: begin
               if (tick) begin
                  if (t_q + 4'd1 == ON_T) begin
                     t_d    = 4'd0;
                     tone_d = '0;
                     if (rem_q == 5'd1) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rem_d   = 5'd0;
                     end else begin
                        state_d = S_GAP;
                        rem_d   = rem_q - 5'd1;
                     end
                  end else begin
                     t_d = t_q + 4'd1;
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (t_q + 4'd1 == GAP_T) begin
                     state_d = S_ON;
                     t_d     = 4'd0;
                     tone_d  = val_q;
                  end else begin
                     t_d = t_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               t_d     = 4'd0;
               rem_d   = 5'd0;
               tone_d  = '0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= 5'd0;
         t_q     <= 4'd0;
         tone_q  <= '0;
         val_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sec_q   <= bus_if.sec;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         t_q     <= t_d;
         tone_q  <= tone_d;
         val_q   <= val_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sec_q   <= bus_if.sec;
      end
   end

   assign bus_if.tone = tone_q;
   assign bus_if.busy = busy_q;
   assign bus_if.done = done_q;
endmodule

// File: tb/tb_hour_chime_ctrl.sv
// Bench for hour_chime_ctrl: three parameter sets share one stimulus, checked against a tick-count model.
module tb_hour_chime_ctrl;
   localparam int P_ON  [3] = '{1, 1, 2};
   localparam int P_GAP [3] = '{1, 1, 3};
   localparam int P_M24 [3] = '{0, 1, 0};
   localparam int P_HALF[3] = '{1, 0, 1};

   logic       clk;
   logic       rst;
   logic       en;
   logic [5:0] hour, min, sec;
   logic [4:0] qs, qe;

   int tests = 0;
   int fails = 0;

   hour_chime_ctrl_if #(.TONE_W(20)) if0 ();
   hour_chime_ctrl_if #(.TONE_W(20)) if1 ();
   hour_chime_ctrl_if #(.TONE_W(20)) if2 ();

   assign if0.en = en; assign if0.hour = hour; assign if0.min = min; assign if0.sec = sec;
   assign if0.quiet_start = qs; assign if0.quiet_end = qe;
   assign if1.en = en; assign if1.hour = hour; assign if1.min = min; assign if1.sec = sec;
   assign if1.quiet_start = qs; assign if1.quiet_end = qe;
   assign if2.en = en; assign if2.hour = hour; assign if2.min = min; assign if2.sec = sec;
   assign if2.quiet_start = qs; assign if2.quiet_end = qe;

   hour_chime_ctrl u0 (.clk(clk), .rst(rst), .bus_if(if0));
   hour_chime_ctrl #(.MODE24(1), .HALF_EN(0)) u1 (.clk(clk), .rst(rst), .bus_if(if1));
   hour_chime_ctrl #(.STRIKE_ON_S(2), .STRIKE_GAP_S(3)) u2 (.clk(clk), .rst(rst), .bus_if(if2));

   logic [19:0] tone_o [3];
   logic        busy_o [3];
   logic        done_o [3];
   assign tone_o[0] = if0.tone; assign busy_o[0] = if0.busy; assign done_o[0] = if0.done;
   assign tone_o[1] = if1.tone; assign busy_o[1] = if1.busy; assign done_o[1] = if1.done;
   assign tone_o[2] = if2.tone; assign busy_o[2] = if2.busy; assign done_o[2] = if2.done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a sequence is a count of elapsed ticks since its trigger.
   bit act    [3];
   int k      [3];
   int tot    [3];
   int mval   [3];
   int e_tone [3];
   bit e_busy [3];
   bit e_done [3];
   int prev_sec;

   function automatic int nstrike(int h, int m24);
      if (m24 != 0) return (h == 0) ? 24 : h;
      return (h % 12 == 0) ? 12 : h % 12;
   endfunction

   function automatic bit is_quiet(int h, int s, int e);
      if (s == e) return 1'b0;
      if (s < e) return (h >= s) && (h < e);
      return (h >= s) || (h < e);
   endfunction

   task automatic model_step();
      bit tick, q, hk, hf;
      int per;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            act[i] = 0; e_tone[i] = 0; e_busy[i] = 0; e_done[i] = 0;
         end
         prev_sec = int'(sec);
      end else begin
         tick = (int'(sec) != prev_sec);
         prev_sec = int'(sec);
         q = is_quiet(int'(hour), int'(qs), int'(qe));
         for (int i = 0; i < 3; i++) begin
            per = P_ON[i] + P_GAP[i];
            e_done[i] = 0;
            if (!en) begin
               act[i] = 0; e_tone[i] = 0; e_busy[i] = 0;
            end else if (act[i]) begin
               if (tick) k[i]++;
               if (k[i] == tot[i]) begin
                  act[i] = 0; e_tone[i] = 0; e_busy[i] = 0; e_done[i] = 1;
               end else begin
                  e_tone[i] = (k[i] % per < P_ON[i]) ? mval[i] : 0;
                  e_busy[i] = 1;
               end
            end else begin
               hk = tick && !q && min == 0 && sec == 0;
               hf = tick && !q && P_HALF[i] != 0 && min == 30 && sec == 0;
               if (hk || hf) begin
                  act[i]  = 1;
                  k[i]    = 0;
                  mval[i] = hk ? 20000 : 30000;
                  tot[i]  = (hk ? nstrike(int'(hour), P_M24[i]) : 1) * per - P_GAP[i];
                  e_tone[i] = mval[i];
                  e_busy[i] = 1;
               end else begin
                  e_tone[i] = 0; e_busy[i] = 0;
               end
            end
         end
      end
   endtask

   task automatic check(string nm, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("model tone u%0d", i), 32'(tone_o[i]), 32'(e_tone[i]));
         check($sformatf("model busy u%0d", i), 32'(busy_o[i]), 32'(e_busy[i]));
         check($sformatf("model done u%0d", i), 32'(done_o[i]), 32'(e_done[i]));
      end
   endtask

   task automatic set_t(int h, int m, int s);
      hour = 6'(h); min = 6'(m); sec = 6'(s);
   endtask

   typedef struct {
      logic rst;
      logic en;
      int   hour, min, sec, qs, qe;
      int   tone;
      logic busy, done;
   } vec_t;

   function automatic vec_t mk(logic r, logic e, int h, int m, int s, int q0, int q1,
                               int t, logic b, logic d);
      vec_t v;
      v.rst = r; v.en = e; v.hour = h; v.min = m; v.sec = s; v.qs = q0; v.qe = q1;
      v.tone = t; v.busy = b; v.done = d;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      rst = 1'b1; en = 1'b1; set_t(0, 0, 0); qs = 5'd0; qe = 5'd0;

      // Hour 3: strikes during sec 0,2,4, done at 5; a held second is not a tick.
      tbl.push_back(mk(1, 1, 3, 59, 59, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 3, 59, 59, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 3,  0,  0, 0, 0, 20000, 1, 0));
      tbl.push_back(mk(0, 1, 3,  0,  1, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 1, 3,  0,  2, 0, 0, 20000, 1, 0));
      tbl.push_back(mk(0, 1, 3,  0,  2, 0, 0, 20000, 1, 0));
      tbl.push_back(mk(0, 1, 3,  0,  3, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 1, 3,  0,  4, 0, 0, 20000, 1, 0));
      tbl.push_back(mk(0, 1, 3,  0,  5, 0, 0, 0,     0, 1));
      tbl.push_back(mk(0, 1, 3,  0,  6, 0, 0, 0,     0, 0));
      // Half hour at 14:30.
      tbl.push_back(mk(1, 1, 14, 29, 59, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 14, 29, 59, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 14, 30,  0, 0, 0, 30000, 1, 0));
      tbl.push_back(mk(0, 1, 14, 30,  1, 0, 0, 0,     0, 1));
      tbl.push_back(mk(0, 1, 14, 30,  2, 0, 0, 0,     0, 0));
      // Quiet 22..7 wraps midnight: 23:00 muted, 07:00 plays.
      tbl.push_back(mk(1, 1, 23, 59, 59, 22, 7, 0,     0, 0));
      tbl.push_back(mk(0, 1, 23,  0,  0, 22, 7, 0,     0, 0));
      tbl.push_back(mk(0, 1, 23,  0,  1, 22, 7, 0,     0, 0));
      tbl.push_back(mk(1, 1,  6, 59, 59, 22, 7, 0,     0, 0));
      tbl.push_back(mk(0, 1,  7,  0,  0, 22, 7, 20000, 1, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; en = tbl[i].en;
         set_t(tbl[i].hour, tbl[i].min, tbl[i].sec);
         qs = 5'(tbl[i].qs); qe = 5'(tbl[i].qe);
         cyc();
         check($sformatf("vec%0d tone", i), 32'(tone_o[0]), 32'(tbl[i].tone));
         check($sformatf("vec%0d busy", i), 32'(busy_o[0]), 32'(tbl[i].busy));
         check($sformatf("vec%0d done", i), 32'(done_o[0]), 32'(tbl[i].done));
      end
      for (int s = 1; s <= 14; s++) begin
         sec = 6'(s); cyc();
         if (s == 12) check("h7 last strike", 32'(tone_o[0]), 32'd20000);
         if (s == 13) check("h7 done", 32'(done_o[0]), 32'd1);
      end

      // Hour 0: 12 strikes in 12h mode, 24 strikes in 24h mode.
      qs = 5'd0; qe = 5'd0;
      rst = 1'b1; set_t(0, 59, 59); cyc(); rst = 1'b0; cyc();
      set_t(0, 0, 0); cyc();
      for (int s = 1; s <= 50; s++) begin
         sec = 6'(s); cyc();
         if (s == 22) check("h0 12h busy", 32'(busy_o[0]), 32'd1);
         if (s == 23) check("h0 12h done", 32'(done_o[0]), 32'd1);
         if (s == 46) check("h0 24h tone", 32'(tone_o[1]), 32'd20000);
         if (s == 47) check("h0 24h done", 32'(done_o[1]), 32'd1);
      end

      // en dropped mid-sequence, then reset mid-sequence.
      rst = 1'b1; set_t(5, 59, 59); cyc(); rst = 1'b0; cyc();
      set_t(5, 0, 0); cyc(); sec = 6'd1; cyc(); sec = 6'd2; cyc();
      en = 1'b0; sec = 6'd3; cyc();
      check("en abort tone", 32'(tone_o[0]), 32'd0);
      check("en abort busy", 32'(busy_o[0]), 32'd0);
      check("en abort done", 32'(done_o[0]), 32'd0);
      en = 1'b1; sec = 6'd4; cyc();
      check("en abort no restart", 32'(busy_o[0]), 32'd0);
      set_t(5, 59, 59); cyc(); set_t(5, 0, 0); cyc(); sec = 6'd1; cyc();
      rst = 1'b1; sec = 6'd2; cyc();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst tone u%0d", i), 32'(tone_o[i]), 32'd0);
         check($sformatf("rst busy u%0d", i), 32'(busy_o[i]), 32'd0);
      end
      rst = 1'b0; cyc();
      check("rst no retrigger", 32'(busy_o[0]), 32'd0);

      // Long strikes (2 on / 3 gap) at hour 2 with the trigger second held.
      rst = 1'b1; set_t(2, 59, 59); cyc(); rst = 1'b0; cyc();
      set_t(2, 0, 0);
      for (int j = 0; j < 4; j++) begin
         cyc();
         check("held sec tone", 32'(tone_o[2]), 32'd20000);
      end
      for (int s = 1; s <= 9; s++) begin
         sec = 6'(s); cyc();
         check($sformatf("long s%0d tone", s), 32'(tone_o[2]),
               (s <= 1 || s == 5 || s == 6) ? 32'd20000 : 32'd0);
         check($sformatf("long s%0d done", s), 32'(done_o[2]), (s == 7) ? 32'd1 : 32'd0);
      end

      // Random walk of the clock with jumps, resets, enable and quiet changes.
      rst = 1'b1; cyc(); rst = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         rst = 1'b0;
         if (r < 55) begin
            if (sec == 6'd59) begin
               sec = 6'd0;
               min = (min == 6'd59) ? 6'd0 : min + 6'd1;
            end else begin
               sec = sec + 6'd1;
            end
         end else if (r < 65) begin
            sec = sec;
         end else if (r < 75) begin
            min = ($urandom_range(0, 1) == 0) ? 6'd59 : 6'd29;
            sec = 6'd59;
         end else if (r < 80) begin
            hour = 6'($urandom_range(0, 23));
         end else if (r < 84) begin
            en = ($urandom_range(0, 3) != 0);
         end else if (r < 86) begin
            rst = 1'b1;
         end else if (r < 90) begin
            qs = 5'($urandom_range(0, 23));
            qe = 5'($urandom_range(0, 23));
         end else begin
            min = 6'($urandom_range(0, 59));
            sec = 6'($urandom_range(0, 59));
         end
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
